// File: rtl/sat_accum_pkg.sv
// Shared types and constants for the saturating accumulator stage.
package sat_accum_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;
  localparam logic [15:0] ZERO16  = 16'h0000;

endpackage

// File: rtl/sat_add16.sv
// 16-bit signed saturating adder/subtractor; clamps the exact 17-bit result.
module sat_add16
  import sat_accum_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic [15:0] Sum,
  output logic        posOvfl,
  output logic        negOvfl
);

  logic [15:0] b_eff_s;
  logic [16:0] sum17_s;

  // Subtract is A + ~B + 1, so overflow is judged on the effective operand.
  always_comb begin
    b_eff_s = sub ? ~B : B;
    sum17_s = {A[15], A} + {b_eff_s[15], b_eff_s} + {16'h0000, sub};
    posOvfl = (sum17_s[16] == 1'b0) && (sum17_s[15] == 1'b1);
    negOvfl = (sum17_s[16] == 1'b1) && (sum17_s[15] == 1'b0);
    if (posOvfl) begin
      Sum = SAT_MAX;
    end else if (negOvfl) begin
      Sum = SAT_MIN;
    end else begin
      Sum = sum17_s[15:0];
    end
  end

endmodule

// File: rtl/sat_accum.sv
// Packet-based saturating accumulator: sums a stream of signed beats and
// presents one clamped result per packet with sticky overflow flags.
module sat_accum
  import sat_accum_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_posOvfl,
  output logic             out_negOvfl,
  output logic             out_zero
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r;
  logic [15:0]      acc_r;
  logic [CNT_W-1:0] count_r;
  logic             pos_r;
  logic             neg_r;
  logic             zero_r;

  logic [15:0]      a_op_s;
  logic [15:0]      sum_s;
  logic             pos_s;
  logic             neg_s;
  logic             fire_s;
  logic [CNT_W-1:0] count_inc_s;

  // Handshake decode and adder operand selection; clr feeds a zero accumulator.
  always_comb begin
    in_ready    = (state_r == ACC) && !rst;
    out_valid   = (state_r == DONE);
    fire_s      = in_valid && in_ready;
    a_op_s      = clr ? ZERO16 : acc_r;
    count_inc_s = (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
  end

  sat_add16 u_add (
    .A       (a_op_s),
    .B       (in_data),
    .sub     (in_sub),
    .Sum     (sum_s),
    .posOvfl (pos_s),
    .negOvfl (neg_s)
  );

  // Accumulator, beat counter, sticky flags and packet FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACC;
      acc_r   <= ZERO16;
      count_r <= CNT_ZERO;
      pos_r   <= 1'b0;
      neg_r   <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      case (state_r)
        ACC: begin
          if (fire_s) begin
            acc_r   <= sum_s;
            count_r <= clr ? CNT_ONE : count_inc_s;
            pos_r   <= (pos_r && !clr) || pos_s;
            neg_r   <= (neg_r && !clr) || neg_s;
            zero_r  <= (sum_s == ZERO16);
            if (in_last) begin
              state_r <= DONE;
            end else begin
              state_r <= ACC;
            end
          end else if (clr) begin
            acc_r   <= ZERO16;
            count_r <= CNT_ZERO;
            pos_r   <= 1'b0;
            neg_r   <= 1'b0;
            zero_r  <= 1'b1;
          end else begin
            state_r <= ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= ACC;
            acc_r   <= ZERO16;
            count_r <= CNT_ZERO;
            pos_r   <= 1'b0;
            neg_r   <= 1'b0;
            zero_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= ACC;
        end
      endcase
    end
  end

  assign out_data    = acc_r;
  assign out_count   = count_r;
  assign out_posOvfl = pos_r;
  assign out_negOvfl = neg_r;
  assign out_zero    = zero_r;

endmodule

// File: tb/tb_sat_accum.sv
// Directed self-checking bench for sat_accum with hand-computed expectations.
module tb_sat_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        out_posOvfl;
  logic        out_negOvfl;
  logic        out_zero;

  int total;
  int bad;

  sat_accum #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sub      (in_sub),
    .in_last     (in_last),
    .clr         (clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_posOvfl (out_posOvfl),
    .out_negOvfl (out_negOvfl),
    .out_zero    (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one beat for a single cycle; the stage must be ready when called.
  task automatic beat(input string tag, input logic [15:0] d, input logic s,
                      input logic l, input logic c);
    chk({tag, ".ready"}, 16'(in_ready), 16'h0001);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_sub   = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic result(input string tag, input logic [15:0] d, input logic [7:0] cnt,
                        input logic p, input logic n, input logic z);
    chk({tag, ".valid"}, 16'(out_valid), 16'h0001);
    chk({tag, ".inrdy"}, 16'(in_ready), 16'h0000);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".count"}, 16'(out_count), 16'(cnt));
    chk({tag, ".pos"}, 16'(out_posOvfl), 16'(p));
    chk({tag, ".neg"}, 16'(out_negOvfl), 16'(n));
    chk({tag, ".zero"}, 16'(out_zero), 16'(z));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".acc_valid"}, 16'(out_valid), 16'h0000);
    chk({tag, ".acc_ready"}, 16'(in_ready), 16'h0001);
    chk({tag, ".acc_data"}, out_data, 16'h0000);
    chk({tag, ".acc_count"}, 16'(out_count), 16'h0000);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    in_sub = 1'b0;
    in_last = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.inrdy", 16'(in_ready), 16'h0000);
    chk("rst.valid", 16'(out_valid), 16'h0000);
    chk("rst.data", out_data, 16'h0000);
    chk("rst.count", 16'(out_count), 16'h0000);
    chk("rst.pos", 16'(out_posOvfl), 16'h0000);
    chk("rst.neg", 16'(out_negOvfl), 16'h0000);
    chk("rst.zero", 16'(out_zero), 16'h0001);
    rst = 1'b0;
    #1;
    chk("rel.inrdy", 16'(in_ready), 16'h0001);
    @(posedge clk);
    #1;

    // 0x7000 + 0x2000 = 0x9000 exact -> clamps high
    beat("t1a", 16'h7000, 1'b0, 1'b0, 1'b0);
    beat("t1b", 16'h2000, 1'b0, 1'b1, 1'b0);
    result("t1", 16'h7FFF, 8'd2, 1'b1, 1'b0, 1'b0);
    accept("t1");

    // -32768 then -1 -> clamps low
    beat("t2a", 16'h8000, 1'b0, 1'b0, 1'b0);
    chk("t2a.mid", out_data, 16'h8000);
    beat("t2b", 16'h0001, 1'b1, 1'b1, 1'b0);
    result("t2", 16'h8000, 8'd2, 1'b0, 1'b1, 1'b0);
    accept("t2");

    // 0 - (-32768) = +32768 -> clamps high
    beat("t3", 16'h8000, 1'b1, 1'b1, 1'b0);
    result("t3", 16'h7FFF, 8'd1, 1'b1, 1'b0, 1'b0);
    accept("t3");

    // saturation does not stick: 0x7FFF - 0x7FFF = 0
    beat("t4a", 16'h7000, 1'b0, 1'b0, 1'b0);
    beat("t4b", 16'h2000, 1'b0, 1'b0, 1'b0);
    beat("t4c", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    result("t4", 16'h0000, 8'd3, 1'b1, 1'b0, 1'b1);
    accept("t4");

    // backpressure; clr in DONE must be ignored
    beat("t5a", 16'h0042, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      clr = (i == 2);
      result("t5hold", 16'h0042, 8'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    result("t5end", 16'h0042, 8'd1, 1'b0, 1'b0, 1'b0);
    accept("t5");
    beat("t5b", 16'h0003, 1'b0, 1'b1, 1'b0);
    result("t5b", 16'h0003, 8'd1, 1'b0, 1'b0, 1'b0);
    accept("t5b");

    // reset mid-packet drops partial sum
    for (int i = 0; i < 3; i++) beat("t6a", 16'h0100, 1'b0, 1'b0, 1'b0);
    chk("t6.mid", out_data, 16'h0300);
    rst = 1'b1;
    #1;
    chk("t6.rst_inrdy", 16'(in_ready), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6.valid", 16'(out_valid), 16'h0000);
    chk("t6.inrdy", 16'(in_ready), 16'h0001);
    chk("t6.data", out_data, 16'h0000);
    chk("t6.count", 16'(out_count), 16'h0000);
    beat("t6b", 16'h0010, 1'b0, 1'b1, 1'b0);
    result("t6b", 16'h0010, 8'd1, 1'b0, 1'b0, 1'b0);
    accept("t6b");

    // clr with a beat restarts from zero with count 1
    beat("t7a", 16'h1000, 1'b0, 1'b0, 1'b0);
    beat("t7b", 16'h1000, 1'b0, 1'b0, 1'b0);
    beat("t7c", 16'h0005, 1'b0, 1'b0, 1'b1);
    chk("t7.count_after_clr", 16'(out_count), 16'h0001);
    beat("t7d", 16'h0001, 1'b0, 1'b1, 1'b0);
    result("t7", 16'h0006, 8'd2, 1'b0, 1'b0, 1'b0);
    accept("t7");

    // clr without a beat clears the overflow flag too
    beat("t8a", 16'h8000, 1'b1, 1'b0, 1'b0);
    chk("t8.pos_mid", 16'(out_posOvfl), 16'h0001);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t8.clr_data", out_data, 16'h0000);
    chk("t8.clr_pos", 16'(out_posOvfl), 16'h0000);
    chk("t8.clr_zero", 16'(out_zero), 16'h0001);
    beat("t8b", 16'h0002, 1'b1, 1'b1, 1'b0);
    result("t8", 16'hFFFE, 8'd1, 1'b0, 1'b0, 1'b0);
    accept("t8");

    // beat counter saturates at 255
    in_valid = 1'b1;
    in_data = 16'h0000;
    repeat (259) @(posedge clk);
    #1;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    result("t9", 16'h0000, 8'd255, 1'b0, 1'b0, 1'b1);
    accept("t9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
